// File: rtl/decode_stage_pkg.sv
// Shared encodings for the decode stage: instruction classes, condition
// codes, NZCV flag positions and the DP compare-opcode range.
package decode_stage_pkg;

  typedef enum logic [1:0] {
    OP_DP    = 2'd0,
    OP_LS    = 2'd1,
    OP_BR    = 2'd2,
    OP_UNDEF = 2'd3
  } op_class_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Bit positions inside the 4-bit NZCV flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST, TEQ, CMP, CMN: DP opcodes that only set flags
  localparam logic [3:0] DP_CMP_LO = 4'b1000;
  localparam logic [3:0] DP_CMP_HI = 4'b1011;

endpackage

// File: rtl/decode_stage_cond_eval.sv
// Combinational ARM condition-code evaluation against NZCV flags.
module cond_eval
  import decode_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Map each condition code to its flag predicate; 1111 never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode stage: decodes an ARM-style instruction word into a
// registered record, with valid/ready handshake and a branch-shadow squash.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BR_SHADOW = 1,
  parameter int LINK_REG  = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [3:0]      flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            cond_pass,
  output logic [1:0]      op_class,
  output logic [3:0]      rd,
  output logic [3:0]      rn,
  output logic [3:0]      rm,
  output logic [3:0]      rs,
  output logic            rs_used,
  output logic            read_reg,
  output logic            wr_reg,
  output logic            is_ls,
  output logic            branch,
  output logic            branch_link,
  output logic [XLEN-1:0] b_offset
);

  logic            cond_ok;
  logic [1:0]      sq_cnt;
  logic            accept;
  op_class_e       d_class;
  logic [3:0]      d_rd, d_rn, d_rm, d_rs;
  logic            d_rs_used, d_read, d_wr, d_ls, d_br, d_link, d_cp;
  logic [XLEN-1:0] d_boff;
  logic [3:0]      dp_opc;
  logic [2:0]      unused_bits;

  assign unused_bits = instruction[7:5];
  assign dp_opc      = instruction[24:21];

  cond_eval u_cond_eval (
    .cond  (instruction[31:28]),
    .flags (flags),
    .pass  (cond_ok)
  );

  // Reset holds the stage open so upstream never stalls on a dead pipe
  assign in_ready = reset || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !reset;

  // Decode the incoming word; squash and UNDEF both force cond_pass low
  always_comb begin
    d_class   = op_class_e'(instruction[27:26]);
    d_rn      = instruction[19:16];
    d_rd      = instruction[15:12];
    d_rm      = 4'd0;
    d_rs      = 4'd0;
    d_rs_used = 1'b0;
    d_read    = 1'b0;
    d_wr      = 1'b0;
    d_ls      = 1'b0;
    d_br      = 1'b0;
    d_link    = 1'b0;
    d_boff    = '0;
    case (d_class)
      OP_DP: begin
        d_read    = 1'b1;
        d_wr      = !((dp_opc >= DP_CMP_LO) && (dp_opc <= DP_CMP_HI));
        d_rs_used = instruction[4] && !instruction[25];
        if (!instruction[25]) d_rm = instruction[3:0];
      end
      OP_LS: begin
        d_ls      = 1'b1;
        d_read    = 1'b1;
        d_wr      = instruction[20];
        d_rs_used = instruction[4] && instruction[25];
        if (instruction[25]) d_rm = instruction[3:0];
      end
      OP_BR: begin
        d_br   = 1'b1;
        d_link = instruction[24];
        d_rn   = 4'd0;
        if (instruction[24]) d_rd = 4'(LINK_REG);
        d_boff = XLEN'({{40{instruction[23]}}, instruction[23:0], 2'b00});
      end
      default: ;
    endcase
    if (d_rs_used) d_rs = instruction[11:8];
    d_cp = cond_ok && (sq_cnt == 2'd0) && (d_class != OP_UNDEF);
  end

  // Output record, valid flag and squash counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      sq_cnt      <= 2'd0;
      cond_pass   <= 1'b0;
      op_class    <= 2'd0;
      rd          <= 4'd0;
      rn          <= 4'd0;
      rm          <= 4'd0;
      rs          <= 4'd0;
      rs_used     <= 1'b0;
      read_reg    <= 1'b0;
      wr_reg      <= 1'b0;
      is_ls       <= 1'b0;
      branch      <= 1'b0;
      branch_link <= 1'b0;
      b_offset    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sq_cnt    <= 2'd0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      cond_pass   <= d_cp;
      op_class    <= d_class;
      rd          <= d_rd;
      rn          <= d_rn;
      rm          <= d_rm;
      rs          <= d_rs;
      rs_used     <= d_rs_used;
      read_reg    <= d_read;
      wr_reg      <= d_wr;
      is_ls       <= d_ls;
      branch      <= d_br;
      branch_link <= d_link;
      b_offset    <= d_boff;
      // A squashed branch only burns a shadow slot; it never reloads
      if (sq_cnt != 2'd0) sq_cnt <= sq_cnt - 2'd1;
      else if (d_br && d_cp) sq_cnt <= 2'(BR_SHADOW);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes hand-computed records,
// a negedge monitor pops and compares whenever a record is presented.
module tb_decode_stage;

  typedef struct packed {
    logic [1:0]  opc;
    logic [3:0]  rd, rn, rm, rs;
    logic [5:0]  fl;   // rs_used, read_reg, wr_reg, is_ls, branch, branch_link
    logic        cp;
    logic [31:0] off;
  } rec_t;

  localparam logic [5:0] F_DP  = 6'b011000;
  localparam logic [5:0] F_DPR = 6'b111000;
  localparam logic [5:0] F_CMP = 6'b010000;
  localparam logic [5:0] F_LD  = 6'b011100;
  localparam logic [5:0] F_LDR = 6'b111100;
  localparam logic [5:0] F_ST  = 6'b010100;
  localparam logic [5:0] F_B   = 6'b000010;
  localparam logic [5:0] F_BL  = 6'b000011;
  localparam logic [5:0] F_NO  = 6'b000000;

  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, cond_pass;
  logic [31:0] instruction = 0;
  logic [3:0]  flags = 0;
  logic [1:0]  op_class;
  logic [3:0]  rd, rn, rm, rs;
  logic        rs_used, read_reg, wr_reg, is_ls, branch, branch_link;
  logic [31:0] b_offset;

  rec_t act;
  rec_t q[$];
  int   errors = 0, checks = 0, cyc = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flags(flags), .out_valid(out_valid), .out_ready(out_ready),
    .cond_pass(cond_pass), .op_class(op_class), .rd(rd), .rn(rn), .rm(rm), .rs(rs),
    .rs_used(rs_used), .read_reg(read_reg), .wr_reg(wr_reg), .is_ls(is_ls),
    .branch(branch), .branch_link(branch_link), .b_offset(b_offset)
  );

  always #5 clk = !clk;
  always @(negedge clk) cyc++;

  always_comb act = {op_class, rd, rn, rm, rs,
                     rs_used, read_reg, wr_reg, is_ls, branch, branch_link,
                     cond_pass, b_offset};

  function automatic rec_t mk(logic [1:0] o, logic [3:0] d, logic [3:0] n, logic [3:0] m,
                              logic [3:0] s, logic [5:0] f, logic c, logic [31:0] b);
    return '{o, d, n, m, s, f, c, b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [3:0] f, input rec_t e);
    int n = 0;
    @(negedge clk);
    in_valid = 1; instruction = ins; flags = f;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
    end else q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: consume on handshake, otherwise require the held record stable
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h expected no record", act);
      end else if (out_ready) chk("record", act, q.pop_front());
      else chk("stall_hold", act, q[0]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_record", act, 0);
    @(negedge clk) reset = 0;

    // Scenario 1 and single-cycle latency / drain
    send(32'hE0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    @(negedge clk) in_valid = 0;
    #1 chk("latency_valid", out_valid, 1);
    @(negedge clk); #1 chk("drain_valid", out_valid, 0);

    // Back-to-back stream: branches, squash, classes, condition codes
    c0 = cyc;
    send(32'hEAFFFFFE, 4'h0, mk(2, 15, 0, 0, 0, F_B, 1, 32'hFFFFFFF8));
    send(32'hE0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 0, 0));
    send(32'hE0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    send(32'hEB000001, 4'h0, mk(2, 14, 0, 0, 0, F_BL, 1, 32'h4));
    send(32'hEC123456, 4'h0, mk(3, 3, 2, 0, 0, F_NO, 0, 0));
    send(32'hEC123456, 4'h0, mk(3, 3, 2, 0, 0, F_NO, 0, 0));
    send(32'h01510002, 4'h0, mk(0, 0, 1, 2, 0, F_CMP, 0, 0));
    send(32'h01510002, 4'h4, mk(0, 0, 1, 2, 0, F_CMP, 1, 0));
    send(32'hE7910002, 4'h0, mk(1, 0, 1, 2, 0, F_LD, 1, 0));
    send(32'hE7910312, 4'h0, mk(1, 0, 1, 2, 3, F_LDR, 1, 0));
    send(32'hE5812004, 4'h0, mk(1, 2, 1, 0, 0, F_ST, 1, 0));
    send(32'hE0812413, 4'h0, mk(0, 2, 1, 3, 4, F_DPR, 1, 0));
    send(32'hE2812015, 4'h0, mk(0, 2, 1, 0, 0, F_DP, 1, 0));
    send(32'hF0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 0, 0));
    send(32'h10812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    send(32'hA0812003, 4'h9, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    send(32'hB0812003, 4'h9, mk(0, 2, 1, 3, 0, F_DP, 0, 0));
    send(32'h80812003, 4'h2, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    send(32'h90812003, 4'h2, mk(0, 2, 1, 3, 0, F_DP, 0, 0));
    send(32'hC0812003, 4'h4, mk(0, 2, 1, 3, 0, F_DP, 0, 0));
    send(32'hD0812003, 4'h4, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    send(32'h0AFFFFFE, 4'h0, mk(2, 15, 0, 0, 0, F_B, 0, 32'hFFFFFFF8));
    send(32'hE0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    send(32'hEAFFFFFE, 4'h0, mk(2, 15, 0, 0, 0, F_B, 1, 32'hFFFFFFF8));
    send(32'hEAFFFFFE, 4'h0, mk(2, 15, 0, 0, 0, F_B, 0, 32'hFFFFFFF8));
    send(32'hE0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    chk("throughput", 64'(cyc - c0), 26);

    // Back-pressure: held record stable, no loss or duplication
    @(negedge clk) in_valid = 0;
    @(negedge clk) out_ready = 0;
    send(32'hE0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) instruction = 32'hE7910002; flags = 0;
      #1 chk("stall_in_ready", in_ready, 0);
    end
    @(negedge clk) out_ready = 1;
    #1 chk("release_in_ready", in_ready, 1);
    q.push_back(mk(1, 0, 1, 2, 0, F_LD, 1, 0));
    @(posedge clk);
    @(negedge clk) in_valid = 0;

    // Flush with a shadow pending; concurrent acceptance must be dropped
    @(negedge clk) out_ready = 0;
    send(32'hEAFFFFFE, 4'h0, mk(2, 15, 0, 0, 0, F_B, 1, 32'hFFFFFFF8));
    @(negedge clk);
    flush = 1; out_ready = 1; instruction = 32'hEC123456;
    @(negedge clk);
    flush = 0; in_valid = 0;
    #1 chk("flush_out_valid", out_valid, 0);
    send(32'hE0812003, 4'h0, mk(0, 2, 1, 3, 0, F_DP, 1, 0));
    @(negedge clk) in_valid = 0;
    repeat (2) @(negedge clk);

    // Reset mid-run clears the stale record and keeps in_ready high
    reset = 1; out_ready = 0; in_valid = 1; instruction = 32'hE0812003;
    #1 chk("reset_hold_ready", in_ready, 1);
    @(negedge clk); #1;
    chk("reset2_ready", in_ready, 1);
    chk("reset2_valid", out_valid, 0);
    chk("reset2_record", act, 0);
    @(negedge clk) reset = 0; in_valid = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    #1 chk("post_reset_valid", out_valid, 0);
    chk("queue_empty", 64'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
